// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_os
//  Description : UART receiver with 2-flop synchroniser, mid-bit 3-sample
//                majority vote, parity/stop checks and valid/ready output.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_os #(
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY       = 0,
    parameter int CLKS_PER_BIT = 1000
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 data_in,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int MID   = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] c_SAMP0    = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] c_SAMP1    = CNT_W'(MID);
    localparam logic [CNT_W-1:0] c_SAMP2    = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       c_STOP_LAST = 4'(STOP_BITS - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_PARITY    = 3'd3;
    localparam logic [2:0] c_STOP      = 3'd4;
    localparam logic [2:0] c_WAIT_IDLE = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic                 rxs_prev_q, rxs_prev_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bit_q, par_bit_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 stop0_q, stop0_d;
    logic [DATA_BITS-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 break_det_q, break_det_d;
    logic                 overrun_q, overrun_d;

    logic w_rxs;
    logic w_fall;
    logic w_in_bit;
    logic w_decide;
    logic w_bit;
    logic w_done;
    logic w_ferr_fin;
    logic w_stop0_fin;
    logic w_brk_fin;
    logic w_par_exp;

    assign w_rxs      = sync_q[1];
    assign w_fall     = (state_q == c_IDLE) && rxs_prev_q && !w_rxs;
    assign w_in_bit   = (state_q != c_IDLE) && (state_q != c_WAIT_IDLE);
    assign w_decide   = w_in_bit && (cnt_q == c_SAMP2);
    assign w_bit      = (samp_q[0] & samp_q[1]) | (samp_q[0] & w_rxs) | (samp_q[1] & w_rxs);
    assign w_done     = w_decide && (state_q == c_STOP) && (bit_idx_q == c_STOP_LAST);
    assign w_ferr_fin = ferr_q | ~w_bit;
    assign w_stop0_fin = (bit_idx_q == 4'd0) ? ~w_bit : stop0_q;
    // par_bit_q never leaves 0 without a parity bit, so break needs no mode test
    assign w_brk_fin  = (shift_q == '0) && !par_bit_q && w_stop0_fin;

    generate
        if (PARITY == 1) begin : g_par_odd
            assign w_par_exp = ~^shift_q;
        end else if (PARITY == 2) begin : g_par_even
            assign w_par_exp = ^shift_q;
        end else begin : g_par_none
            assign w_par_exp = 1'b0;
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (w_fall) state_d = c_START;
            end
            c_START: begin
                if (w_decide) state_d = w_bit ? c_IDLE : c_DATA;
            end
            c_DATA: begin
                if (w_decide && (bit_idx_q == c_DATA_LAST))
                    state_d = (PARITY != 0) ? c_PARITY : c_STOP;
            end
            c_PARITY: begin
                if (w_decide) state_d = c_STOP;
            end
            c_STOP: begin
                if (w_done) state_d = w_ferr_fin ? c_WAIT_IDLE : c_IDLE;
            end
            c_WAIT_IDLE: begin
                if (w_rxs && (cnt_q == c_CNT_LAST)) state_d = c_IDLE;
            end
            default: state_d = c_IDLE;
        endcase
    end

    // Datapath and output logic
    always_comb begin
        sync_d       = {sync_q[0], data_in};
        rxs_prev_d   = w_rxs;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        samp_d       = samp_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        stop0_d      = stop0_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        break_det_d  = break_det_q;
        overrun_d    = 1'b0;

        // WAIT_IDLE reuses the counter to time one full bit of continuous idle
        case (state_q)
            c_IDLE:      cnt_d = '0;
            c_WAIT_IDLE: cnt_d = (!w_rxs || (cnt_q == c_CNT_LAST)) ? '0 : cnt_q + CNT_W'(1);
            default: begin
                if ((w_done && w_ferr_fin) || (cnt_q == c_CNT_LAST)) cnt_d = '0;
                else                                                 cnt_d = cnt_q + CNT_W'(1);
            end
        endcase

        if (cnt_q == c_SAMP0) samp_d[0] = w_rxs;
        if (cnt_q == c_SAMP1) samp_d[1] = w_rxs;

        if (w_decide) begin
            case (state_q)
                c_START: begin
                    bit_idx_d = 4'd0;
                    par_bit_d = 1'b0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                    stop0_d   = 1'b0;
                end
                c_DATA: begin
                    shift_d   = {w_bit, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = (bit_idx_q == c_DATA_LAST) ? 4'd0 : bit_idx_q + 4'd1;
                end
                c_PARITY: begin
                    par_bit_d = w_bit;
                    perr_d    = (w_bit != w_par_exp);
                end
                c_STOP: begin
                    ferr_d    = w_ferr_fin;
                    stop0_d   = w_stop0_fin;
                    bit_idx_d = bit_idx_q + 4'd1;
                end
                default: ;
            endcase
        end

        if (w_done) begin
            if (!out_valid_q || out_ready) begin
                out_data_d   = shift_q;
                out_valid_d  = 1'b1;
                frame_err_d  = w_ferr_fin;
                parity_err_d = perr_q;
                break_det_d  = w_brk_fin;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            sync_q       <= 2'b11;
            rxs_prev_q   <= 1'b1;
            cnt_q        <= '0;
            bit_idx_q    <= 4'd0;
            samp_q       <= 2'b11;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            stop0_q      <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            break_det_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            rxs_prev_q   <= rxs_prev_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            stop0_q      <= stop0_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            break_det_q  <= break_det_d;
            overrun_q    <= overrun_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign break_det  = break_det_q;
    assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: doc/uart_rx_os.md
Name:
uart_rx_os

Overview:
- Parametrised UART receiver for the test harness.
- Synchronises the asynchronous serial line and takes a 3-sample majority vote at mid-bit.
- Configurable data width, parity mode and stop-bit count.
- Delivers received words over a valid/ready handshake, with per-word error sideband (framing, parity, break) and an overrun pulse when the consumer stalls.

Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..9, sent LSB first.
- STOP_BITS, 1, stop bits checked per frame, legal 1..2.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- CLKS_PER_BIT, 1000, clk cycles per bit, legal >= 8; MID = CLKS_PER_BIT/2.

Ports:
- clk  in  1  system clock.
- n_reset  in  1  reset, synchronous, active-low.
- data_in  in  1  asynchronous serial line, idle high.
- out_data  out  DATA_BITS  received word.
- out_valid  out  1  out_data and error flags valid.
- out_ready  in  1  consumer accepts word when out_valid && out_ready.
- frame_err  out  1  sideband: a stop bit sampled 0.
- parity_err  out  1  sideband: parity mismatch (0 when PARITY=0).
- break_det  out  1  sideband: data bits all 0, parity (if any) 0, first stop bit 0.
- overrun  out  1  one-cycle pulse: completed word dropped.

Behaviour:
- Reset: out_valid, frame_err, parity_err, break_det, overrun = 0; out_data = 0; synchroniser flops = 1; state IDLE; counters 0. Reset mid-frame aborts the frame with no output.
- Synchroniser: 2 flops; rxs = second flop. All logic uses rxs only.
- Bit counter cnt:
  - Cleared in the cycle rxs falls (prev 1, now 0) while in IDLE.
  - Otherwise increments while not IDLE and wraps at CLKS_PER_BIT-1.
- Per-bit sampling: rxs is sampled at cnt = MID-1, MID, MID+1. The bit value is the majority of the three samples, decided in the MID+1 cycle.
- States:
  - IDLE: wait for falling edge of rxs, then go to START.
  - START: on decision, a 0 goes to DATA; a 1 (glitch) returns to IDLE with no output.
  - DATA: shift the bit into position bit_idx (LSB first). After bit DATA_BITS-1, go to PARITY if PARITY != 0, else STOP.
  - PARITY: compare the sampled bit against the computed parity (odd: data XOR-reduce inverted; even: data XOR-reduce), then go to STOP.
  - STOP: check each stop bit; any 0 sets the frame error. After the last stop-bit decision the word is complete.
    - If there is no frame error, go to IDLE immediately.
    - If there is a frame error, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs = 1 for one full CLKS_PER_BIT, then go to IDLE. A held break yields exactly one output word.
- Completion:
  - out_data and the flags are loaded, and out_valid rises, the cycle after the final stop decision.
  - Flags are constant while out_valid = 1.
- Latency: from the falling edge on data_in to out_valid is 2 + (1 + DATA_BITS + (PARITY != 0) + STOP_BITS - 1) * CLKS_PER_BIT + MID + 2 cycles (±1 for synchroniser phase).
- Handshake:
  - out_valid holds until out_valid && out_ready, then drops next cycle unless a new word completes in the same cycle.
  - Simultaneous accept and new completion: the new word loads and out_valid stays 1.
  - Completion while out_valid && !out_ready: the held word and flags are kept, the new word is discarded, and overrun pulses 1 cycle.
  - Reception itself never stalls.
- Stop-bit checking ends at the MID+1 of the last stop bit, so the next start edge is caught even with a short stop bit.

Test Plan (CLKS_PER_BIT=16, out_ready=1 unless stated):
- 8N1: send 0xA5 with good framing -> one out_valid, out_data=0xA5, all flags 0. Hold out_ready=0 for 100 cycles -> out_valid stays 1, data stable.
- Glitch rejection: drive data_in low for 4 cycles in idle -> no out_valid, receiver accepts a following 0x3C correctly. Separately, a 1-cycle inverted glitch at MID of data bit 2 in 0x3C -> out_data=0x3C.
- PARITY=2: send 0x07 with parity bit 1 -> out_data=0x07, parity_err=0. Send 0x07 with parity bit 0 -> parity_err=1.
- Break: hold data_in low 3 frame times, then high -> exactly one word: out_data=0x00, frame_err=1, break_det=1. Next 0x55 is received cleanly only after line idle.
- Overrun: out_ready=0, send 0x11 then 0x22 back-to-back -> out_data=0x11 retained, overrun single-cycle pulse at 0x22 completion. Then out_ready=1 -> 0x11 accepted, out_valid drops.
- Reset mid-frame: assert n_reset during DATA bit 4 of 0xF0 -> all outputs 0, no word. The following 0x81 is received correctly; STOP_BITS=2 with second stop bit 0 -> frame_err=1.
